// File: rtl/flag_gen_reg_if.sv
// flag_gen_reg_if
// Purpose: bundles the ALU-result, flag-control and stack-status signals of the
//          condition-flag register into one interface.
// Members:
//   ALU_VALID, ALU_OP_CLASS[1:0], ALU_RESULT[WIDTH-1:0], ALU_A_MSB, ALU_B_MSB,
//   ALU_CARRY_OUT      - current ALU outputs used to derive N/Z/C/V
//   FLAG_WE[3:0]       - per-flag write mask {N,Z,C,V}
//   FLAG_LOAD, FLAG_DATA[3:0] - direct flag load
//   SAVE_REQ, RESTORE_REQ     - push / pop the flag stack
//   ERR_CLR            - clears the sticky stack error
//   FLAG_OUT[3:0]      - registered flags {N,Z,C,V}
//   STACK_EMPTY, STACK_FULL, STACK_ERR - stack status
// Modports: master drives requests and observes status; slave is the flag block.
interface flag_gen_reg_if #(
    parameter int WIDTH = 8
);
    logic             ALU_VALID;
    logic [1:0]       ALU_OP_CLASS;
    logic [WIDTH-1:0] ALU_RESULT;
    logic             ALU_A_MSB;
    logic             ALU_B_MSB;
    logic             ALU_CARRY_OUT;
    logic [3:0]       FLAG_WE;
    logic             FLAG_LOAD;
    logic [3:0]       FLAG_DATA;
    logic             SAVE_REQ;
    logic             RESTORE_REQ;
    logic             ERR_CLR;
    logic [3:0]       FLAG_OUT;
    logic             STACK_EMPTY;
    logic             STACK_FULL;
    logic             STACK_ERR;

    modport master (
        output ALU_VALID, ALU_OP_CLASS, ALU_RESULT, ALU_A_MSB, ALU_B_MSB,
               ALU_CARRY_OUT, FLAG_WE, FLAG_LOAD, FLAG_DATA, SAVE_REQ,
               RESTORE_REQ, ERR_CLR,
        input  FLAG_OUT, STACK_EMPTY, STACK_FULL, STACK_ERR
    );

    modport slave (
        input  ALU_VALID, ALU_OP_CLASS, ALU_RESULT, ALU_A_MSB, ALU_B_MSB,
               ALU_CARRY_OUT, FLAG_WE, FLAG_LOAD, FLAG_DATA, SAVE_REQ,
               RESTORE_REQ, ERR_CLR,
        output FLAG_OUT, STACK_EMPTY, STACK_FULL, STACK_ERR
    );
endinterface

// File: rtl/flag_gen_reg.sv
// flag_gen_reg
// Purpose: derives N/Z/C/V from each ALU result, applies them under a per-flag
//          write mask, holds them for the branch condition checker, and keeps a
//          small LIFO of saved flag values for interrupt entry/return.
// Ports:
//   LOGISIM_CLOCK_TREE_0[4:0] - bit 4 is the clock (rising edge); bits 3:0 unused
//   RESET                     - synchronous, active-high
//   bus (flag_gen_reg_if.slave) - ALU inputs, flag controls, flags and status
// Priority on each edge: RESET > RESTORE > LOAD > ALU update.
module flag_gen_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic [4:0]           LOGISIM_CLOCK_TREE_0,
    input  logic                 RESET,
    flag_gen_reg_if.slave        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOGIC = 2'b10;

    logic       clk;
    logic [3:0] unused_clk_bits;
    assign clk             = LOGISIM_CLOCK_TREE_0[4];
    assign unused_clk_bits = LOGISIM_CLOCK_TREE_0[3:0];

    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [3:0]    stack_mem_q [DEPTH];

    logic          empty, full;
    logic          save_ok, restore_ok, err_event;
    logic [PW-1:0] wr_idx, top_idx;
    logic [3:0]    derived, we_eff, alu_flags;
    logic          n_bit;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A simultaneous SAVE and RESTORE cancels both stack operations.
    assign save_ok    = bus.SAVE_REQ & ~bus.RESTORE_REQ & ~full;
    assign restore_ok = bus.RESTORE_REQ & ~bus.SAVE_REQ & ~empty;
    assign err_event  = (bus.SAVE_REQ & bus.RESTORE_REQ)
                      | (bus.SAVE_REQ & full)
                      | (bus.RESTORE_REQ & empty);

    assign wr_idx  = count_q[PW-1:0];
    assign top_idx = count_q[PW-1:0] - PW'(1);

    // Flag derivation, bit order {N,Z,C,V}.
    assign n_bit      = bus.ALU_RESULT[WIDTH-1];
    assign derived[3] = n_bit;
    assign derived[2] = (bus.ALU_RESULT == '0);
    assign derived[1] = bus.ALU_CARRY_OUT;
    assign derived[0] = (bus.ALU_OP_CLASS == OP_SUB)
                      ? ((bus.ALU_A_MSB != bus.ALU_B_MSB) && (n_bit != bus.ALU_A_MSB))
                      : ((bus.ALU_A_MSB == bus.ALU_B_MSB) && (n_bit != bus.ALU_A_MSB));

    // C is held for logic ops; V is held for logic and shift ops.
    assign we_eff = bus.FLAG_WE & {1'b1, 1'b1,
                                   (bus.ALU_OP_CLASS != OP_LOGIC),
                                   (bus.ALU_OP_CLASS == OP_ADD) || (bus.ALU_OP_CLASS == OP_SUB)};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flag_mux
            assign alu_flags[gi] = we_eff[gi] ? derived[gi] : flags_q[gi];
        end
    endgenerate

    always_comb begin
        flags_d = flags_q;
        count_d = count_q;
        if (restore_ok) begin
            flags_d = stack_mem_q[top_idx];
        end else if (bus.FLAG_LOAD) begin
            flags_d = bus.FLAG_DATA;
        end else if (bus.ALU_VALID) begin
            flags_d = alu_flags;
        end
        if (save_ok) begin
            count_d = count_q + CW'(1);
        end else if (restore_ok) begin
            count_d = count_q - CW'(1);
        end
        // A new error wins over a clear in the same cycle.
        err_d = err_event | (err_q & ~bus.ERR_CLR);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            flags_q <= 4'b0000;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage needs no reset: the count alone defines valid entries.
    // The pushed value is the pre-edge FLAG_OUT.
    always_ff @(posedge clk) begin
        if (save_ok && !RESET) begin
            stack_mem_q[wr_idx] <= flags_q;
        end
    end

    assign bus.FLAG_OUT    = flags_q;
    assign bus.STACK_EMPTY = empty;
    assign bus.STACK_FULL  = full;
    assign bus.STACK_ERR   = err_q;
endmodule
